img_stream_loader: RTL and testbench
====================================

Name: img_stream_loader

Overview:
- Upstream image-load stage for the VGA display path.
- Accepts an RGB332 pixel byte stream over a valid/ready handshake and writes one full IMG_W x IMG_H frame into the write port of the image memory, raster order.
- The VGA display stage reads the same memory at pixel address ((v*IMG_W)+h).
- Frame arm, start-of-frame sync, completion pulse and error flag for a host/UART front end.

Parameters:
- IMG_W, 256, pixels per image row
- IMG_H, 256, image rows per frame
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- PIX_W, 8, pixel width (RGB332)

Ports:
- CLK  in  1  system clock; all logic on posedge CLK
- RSTN  in  1  reset; synchronous, active-high (RSTN=1 resets)
- START  in  1  arm a frame load; sampled only in IDLE
- S_VALID  in  1  input beat valid
- S_READY  out  1  loader accepts beat when S_VALID&S_READY
- S_DATA  in  PIX_W  pixel byte, RGB332 {R[7:5],G[4:2],B[1:0]}
- S_SOF  in  1  marks first pixel of a frame, qualified by S_VALID
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory write address (ADDR_W+1 with DOUBLE_BUFFER_EN)
- MEM_WDATA  out  PIX_W  memory write data
- BUSY  out  1  high in WAIT_SOF and LOAD
- DONE  out  1  one-cycle pulse after last pixel written
- ERR_SOF  out  1  sticky: S_SOF seen mid-frame; cleared by START or reset

Behaviour:
- Reset (RSTN=1 at an edge): state=IDLE; S_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, DONE=0, ERR_SOF=0; col=row=0. Applies mid-load: the pending write is dropped, and MEM_WE is 0 from the following cycle.
- FSM:
  - IDLE: S_READY=0. START=1 -> WAIT_SOF; clear ERR_SOF.
  - WAIT_SOF: S_READY=1. Accepted beats with S_SOF=0 are discarded (no write). Accepted beat with S_SOF=1 is pixel 0 (addr 0) -> LOAD, col=1.
  - LOAD: S_READY=1. Each accepted beat is written at the running address, then col++. When col wraps at IMG_W-1, col=0 and row++.
  - LOAD exit: accepting the beat with row=IMG_H-1, col=IMG_W-1 -> DONE_ST.
  - DONE_ST: S_READY=0, DONE=1 for exactly this cycle -> IDLE.
- Address: maintained as an incrementing counter, not a multiplier. Value = row*IMG_W+col, truncated to ADDR_W.
- Write latency: one cycle. A beat accepted at edge N gives MEM_WE=1, MEM_ADDR, MEM_WDATA valid between edges N and N+1. MEM_WE=0 in any cycle with no accept.
- Backpressure: S_READY does not depend combinationally on S_VALID. S_VALID=0 stalls without state change. Back-to-back accepts every cycle are sustained.
- Mid-frame SOF: S_SOF=1 accepted in LOAD while (row,col)!=(0,0) sets ERR_SOF. The beat is written to addr 0 and the counters restart (col=1,row=0); state stays LOAD.
- START outside IDLE is ignored. START in the same cycle as RSTN=1 is ignored (reset wins).
- DONE and the last MEM_WE: the last write occurs in the DONE_ST cycle.

Optional Feature:
- Macro: DOUBLE_BUFFER_EN.
- When defined:
  - MEM_ADDR is ADDR_W+1 bits; MSB = write bank.
  - New output DISP_BANK (1 bit) selects the bank the display reads.
  - Write bank is reset to 0 and DISP_BANK to 1.
  - On DONE the write bank toggles and DISP_BANK takes the just-completed bank in the same edge. Display never reads a partially written frame.
- When undefined: single bank, MEM_ADDR is ADDR_W bits, no DISP_BANK port.

Test Plan:
- IMG_W=4,IMG_H=2; START, then 8 beats 0x00..0x07 with S_SOF on the first, S_VALID=1 continuous -> MEM_WE on 8 consecutive cycles, addr 0..7, data 0x00..0x07, DONE one cycle in the 8th write cycle, then IDLE with S_READY=0.
- Same config; 3 beats with S_SOF=0 before the SOF beat -> no writes for the first 3; the SOF beat lands at addr 0, the remaining 7 at 1..7.
- S_VALID toggled 1,0,1,0 -> writes only on accept cycles, addresses contiguous, no duplicates, DONE after the 8th accept.
- SOF reasserted on the 5th beat with data 0xAA -> ERR_SOF=1 and stays 1; 0xAA written at addr 0; DONE only after 8 further beats; next START clears ERR_SOF.
- RSTN=1 after 3 beats -> MEM_WE=0 next cycle, state IDLE, S_READY=0; a new START+SOF frame begins at addr 0.
- DOUBLE_BUFFER_EN, default IMG size, two full frames -> frame 1 writes MEM_ADDR MSB=0 and DISP_BANK goes 1->0 at DONE; frame 2 writes MSB=1 and DISP_BANK goes 0->1.

Source files
------------

// File: rtl/img_stream_loader.sv
// img_stream_loader
//   Front-end image loader for the VGA display path. Takes an RGB332 pixel
//   byte stream over a valid/ready handshake and writes exactly one
//   IMG_W x IMG_H frame into the image memory write port in raster order,
//   so that the display can read pixel (h,v) at address v*IMG_W+h.
//
//   Ports
//     CLK        system clock, posedge
//     RSTN       synchronous reset, active HIGH despite the name
//     START      arm a frame load (only honoured in IDLE)
//     S_VALID/S_READY/S_DATA/S_SOF   pixel stream, S_SOF marks pixel 0
//     MEM_WE/MEM_ADDR/MEM_WDATA      registered memory write port
//     BUSY       waiting for SOF or loading
//     DONE       one-cycle pulse, coincides with the last write
//     ERR_SOF    sticky: SOF arrived mid-frame; cleared by START or reset
//
//   Optional build macro DOUBLE_BUFFER_EN: MEM_ADDR grows by one MSB that
//   selects the write bank, and DISP_BANK tells the display which bank
//   holds the most recently completed frame.
module img_stream_loader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [PIX_W-1:0]  S_DATA,
  input  logic              S_SOF,
  output logic              MEM_WE,
`ifdef DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   MEM_ADDR,
  output logic              DISP_BANK,
`else
  output logic [ADDR_W-1:0] MEM_ADDR,
`endif
  output logic [PIX_W-1:0]  MEM_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_SOF
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, LOAD, DONE_ST} state_t;

  state_t state, state_nx;

  logic [COL_W-1:0]  col, eff_col, col_nx;
  logic [ROW_W-1:0]  row, eff_row, row_nx;
  logic [ADDR_W-1:0] addr, eff_addr, addr_nx;
  logic              accept, restart, pix_acc, last, mid_sof;
`ifdef DOUBLE_BUFFER_EN
  logic              wr_bank;
`endif

  assign accept  = S_VALID & S_READY;
  // Pixel 0 either comes from WAIT_SOF or from any SOF beat in LOAD; in both
  // cases the beat is placed at (0,0) regardless of the running counters.
  assign restart = (state == WAIT_SOF) | S_SOF;
  // In WAIT_SOF only the SOF beat is a pixel; non-SOF beats are drained.
  assign pix_acc = accept & ((state == LOAD) | S_SOF);
  assign mid_sof = accept & (state == LOAD) & S_SOF &
                   ((col != '0) | (row != '0));

  assign eff_col  = restart ? '0 : col;
  assign eff_row  = restart ? '0 : row;
  assign eff_addr = restart ? '0 : addr;
  assign last     = (eff_col == COL_LAST) & (eff_row == ROW_LAST);

  // Position of the next pixel; the address runs as its own counter so no
  // row*IMG_W multiply is needed. Counters park at zero after the last pixel.
  always_comb begin
    col_nx  = eff_col + COL_W'(1);
    row_nx  = eff_row;
    addr_nx = eff_addr + ADDR_W'(1);
    if (eff_col == COL_LAST) begin
      col_nx = '0;
      row_nx = eff_row + ROW_W'(1);
    end
    if (last) begin
      col_nx  = '0;
      row_nx  = '0;
      addr_nx = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RSTN) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:           if (START) state_nx = WAIT_SOF;
      WAIT_SOF, LOAD: if (pix_acc) state_nx = last ? DONE_ST : LOAD;
      DONE_ST:        state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // FSM: outputs (S_READY is a pure function of state, never of S_VALID)
  always_comb begin
    S_READY = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    unique case (state)
      WAIT_SOF, LOAD: begin
        S_READY = 1'b1;
        BUSY    = 1'b1;
      end
      DONE_ST: DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath: registered write port, position counters, error flag, banks.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      ERR_SOF   <= 1'b0;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
`ifdef DOUBLE_BUFFER_EN
      wr_bank   <= 1'b0;
      DISP_BANK <= 1'b1;
`endif
    end else begin
      MEM_WE <= pix_acc;
      if (pix_acc) begin
`ifdef DOUBLE_BUFFER_EN
        MEM_ADDR <= {wr_bank, eff_addr};
`else
        MEM_ADDR <= eff_addr;
`endif
        MEM_WDATA <= S_DATA;
        col       <= col_nx;
        row       <= row_nx;
        addr      <= addr_nx;
      end
      if ((state == IDLE) && START) ERR_SOF <= 1'b0;
      else if (mid_sof)             ERR_SOF <= 1'b1;
`ifdef DOUBLE_BUFFER_EN
      // Swap at the end of DONE_ST, after the last write has been issued, so
      // the display never points at a bank that is still being written.
      if (state == DONE_ST) begin
        wr_bank   <= ~wr_bank;
        DISP_BANK <= wr_bank;
      end
`endif
    end
  end

endmodule

// File: tb/tb_img_stream_loader.sv
// tb_img_stream_loader
//   Directed bench for img_stream_loader with a 4x2 image: clean frame,
//   pre-SOF drain, valid gaps, mid-frame SOF error, mid-load reset.
//   Builds with or without DOUBLE_BUFFER_EN.
module tb_img_stream_loader;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 3;
  localparam int PIX_W  = 8;

  logic              CLK = 1'b0;
  logic              RSTN, START, S_VALID, S_SOF;
  logic [PIX_W-1:0]  S_DATA;
  logic              S_READY, MEM_WE, BUSY, DONE, ERR_SOF;
  logic [PIX_W-1:0]  MEM_WDATA;
`ifdef DOUBLE_BUFFER_EN
  logic [ADDR_W:0]   MEM_ADDR;
  logic              DISP_BANK;
`else
  logic [ADDR_W-1:0] MEM_ADDR;
`endif

  img_stream_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_SOF(S_SOF),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
`ifdef DOUBLE_BUFFER_EN
    .DISP_BANK(DISP_BANK),
`endif
    .MEM_WDATA(MEM_WDATA), .BUSY(BUSY), .DONE(DONE), .ERR_SOF(ERR_SOF)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int wbank = 0;  // bank the next frame is expected to be written into

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stream inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic v, input logic sof, input logic [7:0] d);
    S_VALID = v;
    S_SOF   = sof;
    S_DATA  = d;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ea(input int i);
    return 32'(i + (wbank << ADDR_W));
  endfunction

  task automatic arm();
    START = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    START = 1'b0;
    chk("arm_busy", 32'(BUSY), 1);
    chk("arm_rdy", 32'(S_READY), 1);
  endtask

  task automatic wr(input string tag, input int i, input logic sof, input logic [7:0] d, input logic lst);
    cyc(1'b1, sof, d);
    chk({tag, "_we"},   32'(MEM_WE), 1);
    chk({tag, "_addr"}, 32'(MEM_ADDR), ea(i));
    chk({tag, "_data"}, 32'(MEM_WDATA), 32'(d));
    chk({tag, "_done"}, 32'(DONE), 32'(lst));
  endtask

  // Call right after the DONE cycle has been sampled.
  task automatic finish_frame();
`ifdef DOUBLE_BUFFER_EN
    chk("disp_hold", 32'(DISP_BANK), 32'((~wbank) & 1));
`endif
    cyc(1'b1, 1'b0, 8'h00);
    chk("post_we",   32'(MEM_WE), 0);
    chk("post_done", 32'(DONE), 0);
    chk("post_rdy",  32'(S_READY), 0);
    chk("post_busy", 32'(BUSY), 0);
`ifdef DOUBLE_BUFFER_EN
    chk("disp_swap", 32'(DISP_BANK), 32'(wbank));
    wbank ^= 1;
`endif
  endtask

  initial begin
    RSTN = 1'b1; START = 1'b0; S_VALID = 1'b0; S_SOF = 1'b0; S_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdy",  32'(S_READY), 0);
    chk("rst_we",   32'(MEM_WE), 0);
    chk("rst_addr", 32'(MEM_ADDR), 0);
    chk("rst_wd",   32'(MEM_WDATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err",  32'(ERR_SOF), 0);
`ifdef DOUBLE_BUFFER_EN
    chk("rst_disp", 32'(DISP_BANK), 1);
`endif
    RSTN = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    chk("idle_busy", 32'(BUSY), 0);

    // 1: clean back-to-back frame
    arm();
    for (int i = 0; i < 8; i++) wr("t1", i, i == 0, 8'(i), i == 7);
    finish_frame();

    // 2: non-SOF beats before SOF are drained without writes
    arm();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'(8'hF0 + i));
      chk("t2_skip_we", 32'(MEM_WE), 0);
      chk("t2_skip_busy", 32'(BUSY), 1);
    end
    for (int i = 0; i < 8; i++) wr("t2", i, i == 0, 8'(8'h10 + i), i == 7);
    finish_frame();

    // 3: valid gaps; START during load must be ignored
    arm();
    for (int i = 0; i < 8; i++) begin
      wr("t3", i, i == 0, 8'(8'h20 + i), i == 7);
      if (i < 7) begin
        START = 1'b1;
        cyc(1'b0, 1'b0, 8'h55);
        START = 1'b0;
        chk("t3_stall_we", 32'(MEM_WE), 0);
        chk("t3_stall_done", 32'(DONE), 0);
        chk("t3_stall_busy", 32'(BUSY), 1);
      end
    end
    finish_frame();

    // 4: SOF on the 5th beat restarts the frame and sets the sticky error
    arm();
    for (int i = 0; i < 4; i++) wr("t4a", i, i == 0, 8'(8'h30 + i), 1'b0);
    chk("t4_err_pre", 32'(ERR_SOF), 0);
    wr("t4_sof", 0, 1'b1, 8'hAA, 1'b0);
    chk("t4_err_set", 32'(ERR_SOF), 1);
    for (int i = 1; i < 8; i++) begin
      wr("t4b", i, 1'b0, 8'(8'h40 + i), i == 7);
      chk("t4_err_hold", 32'(ERR_SOF), 1);
    end
    finish_frame();
    chk("t4_err_idle", 32'(ERR_SOF), 1);
    arm();
    chk("t4_err_clr", 32'(ERR_SOF), 0);

    // 5: reset after 3 beats (with START held in the reset cycle)
    for (int i = 0; i < 3; i++) wr("t5a", i, i == 0, 8'(8'h50 + i), 1'b0);
    RSTN = 1'b1;
    START = 1'b1;
    cyc(1'b1, 1'b1, 8'h77);
    RSTN = 1'b0;
    START = 1'b0;
    chk("t5_we",   32'(MEM_WE), 0);
    chk("t5_rdy",  32'(S_READY), 0);
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_addr", 32'(MEM_ADDR), 0);
    wbank = 0;
`ifdef DOUBLE_BUFFER_EN
    chk("t5_disp", 32'(DISP_BANK), 1);
`endif
    cyc(1'b1, 1'b1, 8'h77);
    chk("t5_idle_we", 32'(MEM_WE), 0);
    chk("t5_idle_busy", 32'(BUSY), 0);
    arm();
    for (int i = 0; i < 8; i++) wr("t5b", i, i == 0, 8'(8'h60 + i), i == 7);
    finish_frame();

    // 6: one more frame (exercises the bank swap back when double-buffered)
    arm();
    for (int i = 0; i < 8; i++) wr("t6", i, i == 0, 8'(8'h70 + i), i == 7);
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
